// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer_if
// Brief    : Start/config/status bundle between flow control and UART TX.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_serializer_if #(
    parameter int DIV_W    = 16,
    parameter int DATA_MAX = 8
);
    logic                tx_enable_i;
    logic [DATA_MAX-1:0] tx_data_i;
    logic [1:0]          data_bits_i;
    logic                parity_en_i;
    logic                parity_odd_i;
    logic                stop2_i;
    logic [DIV_W-1:0]    baud_div_i;
    logic                tx_o;
    logic                tx_busy_o;
    logic                tx_done_o;

    modport master (
        output tx_enable_i, tx_data_i, data_bits_i, parity_en_i,
               parity_odd_i, stop2_i, baud_div_i,
        input  tx_o, tx_busy_o, tx_done_o
    );

    modport slave (
        input  tx_enable_i, tx_data_i, data_bits_i, parity_en_i,
               parity_odd_i, stop2_i, baud_div_i,
        output tx_o, tx_busy_o, tx_done_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : UART frame serializer (start, 5-8 data LSB first, parity, 1/2 stop).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int DIV_W    = 16,
    parameter int DATA_MAX = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    uart_tx_serializer_if.slave bus
);
    localparam int               IDX_W     = (DATA_MAX > 1) ? $clog2(DATA_MAX) : 1;
    localparam logic [DIV_W-1:0] c_DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    period_q, period_d;
    logic [IDX_W-1:0]    bit_q, bit_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [DATA_MAX-1:0] shreg_q, shreg_d;
    logic                par_q, par_d;
    logic                pen_q, pen_d;
    logic                stop2_q, stop2_d;
    logic                stop_sec_q, stop_sec_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_MAX-1:0] w_mask;
    logic                w_bit_end;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_MAX; i++) begin
            if (i < 5 + int'(bus.data_bits_i)) w_mask[i] = 1'b1;
        end
    end

    assign w_bit_end = (cnt_q == period_q - c_DIV_ONE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        bit_d      = bit_q;
        last_d     = last_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        pen_d      = pen_q;
        stop2_d    = stop2_q;
        stop_sec_d = stop_sec_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (state_q != S_IDLE) cnt_d = w_bit_end ? '0 : cnt_q + c_DIV_ONE;

        case (state_q)
            S_IDLE: begin
                if (bus.tx_enable_i) begin
                    // Parity is fixed at accept time from the masked byte.
                    state_d  = S_START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    shreg_d  = bus.tx_data_i;
                    last_d   = IDX_W'(4) + IDX_W'(bus.data_bits_i);
                    par_d    = (^(bus.tx_data_i & w_mask)) ^ bus.parity_odd_i;
                    pen_d    = bus.parity_en_i;
                    stop2_d  = bus.stop2_i;
                    period_d = (bus.baud_div_i == '0) ? c_DIV_ONE : bus.baud_div_i;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (bit_q == last_q) begin
                        stop_sec_d = 1'b0;
                        if (pen_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_sec_d = 1'b0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            bit_q      <= '0;
            last_q     <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            pen_q      <= 1'b0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            pen_q      <= pen_d;
            stop2_q    <= stop2_d;
            stop_sec_q <= stop_sec_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_o      = tx_q;
    assign bus.tx_busy_o = busy_q;
    assign bus.tx_done_o = done_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_serializer
// Brief    : Scoreboard bench; expected line waveform built from frame rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;
    logic clk;
    logic reset;

    uart_tx_serializer_if #(.DIV_W(16), .DATA_MAX(8)) bus ();

    uart_tx_serializer #(.DIV_W(16), .DATA_MAX(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  db;
        bit          pen;
        bit          odd;
        bit          s2;
        logic [15:0] baud_div;
    } frame_t;

    frame_t exp_q[$];
    logic   obs[$];
    logic   busy_prev;
    int     n_tests;
    int     n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected waveform: each frame bit repeated P times, P = max(baud_div,1).
    task automatic check_frame();
        frame_t f;
        logic   w[$];
        logic   bits[$];
        int     p;
        int     n;
        logic   par;
        int     bad;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0d busy cycles, required no frame", obs.size());
            return;
        end
        f = exp_q.pop_front();
        p = (f.baud_div == 16'd0) ? 1 : int'(f.baud_div);
        n = 5 + int'(f.db);
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) bits.push_back(f.data[i]);
        if (f.pen) begin
            par = f.odd;
            for (int i = 0; i < n; i++) par = par ^ f.data[i];
            bits.push_back(par);
        end
        bits.push_back(1'b1);
        if (f.s2) bits.push_back(1'b1);
        foreach (bits[i]) repeat (p) w.push_back(bits[i]);

        n_tests++;
        if (obs.size() != w.size()) begin
            n_fail++;
            $display("FAIL busy_len: got %0d cycles, required %0d", obs.size(), w.size());
        end
        bad = -1;
        for (int i = 0; i < w.size() && i < obs.size(); i++)
            if (obs[i] !== w[i] && bad < 0) bad = i;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL wave: data=%h cycle %0d got tx=%b, required %b", f.data, bad, obs[bad], w[bad]);
        end
        n_tests++;
        if (bus.tx_done_o !== 1'b1 || bus.tx_o !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b tx=%b, required done=1 tx=1", bus.tx_done_o, bus.tx_o);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            obs.delete();
            busy_prev = 1'b0;
        end else begin
            if (bus.tx_busy_o) obs.push_back(bus.tx_o);
            if (busy_prev && !bus.tx_busy_o) begin
                check_frame();
                obs.delete();
            end else if (bus.tx_done_o) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_done: got tx_done=1 outside frame end, required 0");
            end
            busy_prev = bus.tx_busy_o;
        end
    end

    // Called at a negedge; returns at the negedge of the first frame cycle.
    task automatic issue(input logic [7:0] d, input logic [1:0] db, input bit pen,
                         input bit odd, input bit s2, input logic [15:0] bd);
        frame_t f;
        f.data = d; f.db = db; f.pen = pen; f.odd = odd; f.s2 = s2; f.baud_div = bd;
        exp_q.push_back(f);
        bus.tx_enable_i  = 1'b1;
        bus.tx_data_i    = d;
        bus.data_bits_i  = db;
        bus.parity_en_i  = pen;
        bus.parity_odd_i = odd;
        bus.stop2_i      = s2;
        bus.baud_div_i   = bd;
        @(negedge clk);
        bus.tx_enable_i  = 1'b0;
    endtask

    // Returns at the negedge of the tx_done cycle; optionally disturbs inputs mid-frame.
    task automatic wait_done(input bit junk);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(negedge clk);
            if (bus.tx_done_o === 1'b1) begin
                seen = 1'b1;
                bus.tx_enable_i = 1'b0;
            end else if (junk && $urandom_range(0, 5) == 0) begin
                bus.tx_enable_i  = 1'b1;
                bus.tx_data_i    = 8'($urandom());
                bus.data_bits_i  = 2'($urandom_range(0, 3));
                bus.parity_en_i  = 1'($urandom_range(0, 1));
                bus.parity_odd_i = 1'($urandom_range(0, 1));
                bus.stop2_i      = 1'($urandom_range(0, 1));
                bus.baud_div_i   = 16'($urandom_range(0, 9));
            end else begin
                bus.tx_enable_i = 1'b0;
            end
        end
        bus.tx_enable_i = 1'b0;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: got no tx_done in 4000 cycles, required one");
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        busy_prev = 1'b0;
        reset = 1'b1;
        bus.tx_enable_i  = 1'b0;
        bus.tx_data_i    = 8'h00;
        bus.data_bits_i  = 2'b11;
        bus.parity_en_i  = 1'b0;
        bus.parity_odd_i = 1'b0;
        bus.stop2_i      = 1'b0;
        bus.baud_div_i   = 16'd1;
        repeat (3) @(negedge clk);
        expect_bit("reset_tx",   bus.tx_o,      1'b1);
        expect_bit("reset_busy", bus.tx_busy_o, 1'b0);
        expect_bit("reset_done", bus.tx_done_o, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 P=4, 7E2 P=2, 5O1 P=3, 8N1 baud_div=0
        issue(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 16'd4); wait_done(1'b0); repeat (2) @(negedge clk);
        issue(8'h7F, 2'b10, 1'b1, 1'b0, 1'b1, 16'd2); wait_done(1'b0); repeat (2) @(negedge clk);
        issue(8'hE0, 2'b00, 1'b1, 1'b1, 1'b0, 16'd3); wait_done(1'b0); repeat (2) @(negedge clk);
        issue(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 16'd0); wait_done(1'b0); repeat (2) @(negedge clk);

        // Mid-frame disturbance, then back-to-back start on the tx_done cycle
        issue(8'h3C, 2'b11, 1'b1, 1'b0, 1'b0, 16'd5);
        wait_done(1'b1);
        issue(8'h96, 2'b01, 1'b1, 1'b1, 1'b1, 16'd2);
        expect_bit("b2b_busy", bus.tx_busy_o, 1'b1);
        expect_bit("b2b_start_bit", bus.tx_o, 1'b0);
        wait_done(1'b0);
        repeat (2) @(negedge clk);

        // Reset during data bit 3 of an 8N1 P=4 frame
        issue(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 16'd4);
        repeat (17) @(negedge clk);
        expect_bit("pre_reset_busy", bus.tx_busy_o, 1'b1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        expect_bit("async_reset_tx",   bus.tx_o,      1'b1);
        expect_bit("async_reset_busy", bus.tx_busy_o, 1'b0);
        repeat (2) @(negedge clk);
        expect_bit("reset_no_done", bus.tx_done_o, 1'b0);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        expect_bit("post_reset_idle_done", bus.tx_done_o, 1'b0);
        issue(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 16'd4); wait_done(1'b0);
        repeat (2) @(negedge clk);

        // Randomized frames with random gaps (0 = back-to-back) and mid-frame noise
        for (int t = 0; t < 40; t++) begin
            issue(8'($urandom()), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 7)));
            wait_done(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d frames outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
